agendador_medidas_dht11: RTL and testbench

Downstream consumer and scheduler for the DHT11 measurement block. Periodically pulses that block's medir input and waits for its pronto/erro handshake. Captures valid temperature/humidity into a 4-sample moving average and drives a temperature alarm with hysteresis. Counts consecutive failed measurements and flags a sensor fault.

---
 rtl/agendador_medidas_dht11.sv | 181 ++++++++++++++++++
 tb/tb_agendador_medidas_dht11.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/agendador_medidas_dht11.sv
// Scheduler for the DHT11 measurement block: triggers periodic measurements and tracks the pronto/erro handshake.
// Keeps a 4-sample moving average of temperature and humidity, a hysteresis alarm, and a consecutive-failure fault flag.
module agendador_medidas_dht11 #(
    parameter int PERIODO          = 100_000_000,
    parameter int TIMEOUT_RESPOSTA = 150_000_000,
    parameter int MAX_ERROS        = 3,
    parameter int HISTERESE        = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        habilitar,
    input  logic        medir_agora,
    input  logic        pronto,
    input  logic        erro,
    input  logic [15:0] temperatura,
    input  logic [15:0] umidade,
    input  logic [7:0]  limiar_temp,
    output logic        medir,
    output logic [7:0]  temp_media,
    output logic [7:0]  umid_media,
    output logic        dado_valido,
    output logic        alarme,
    output logic        falha_sensor,
    output logic [3:0]  contagem_erros,
    output logic [2:0]  db_estado
);
    localparam int PW = $clog2(PERIODO + 1);
    localparam int TW = $clog2(TIMEOUT_RESPOSTA + 1);
    localparam logic [PW-1:0] PERIODO_ULT = PW'(PERIODO - 1);
    localparam logic [TW-1:0] TIMEOUT_ULT = TW'(TIMEOUT_RESPOSTA - 1);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ESPERA   = 3'd1,
        DISPARA  = 3'd2,
        AGUARDA  = 3'd3,
        REGISTRA = 3'd4,
        FALHA    = 3'd5
    } estado_t;

    estado_t       estado_reg, estado_next;
    logic [PW-1:0] periodo_cnt_reg;
    logic [TW-1:0] timeout_cnt_reg;
    logic [7:0]    temp_amostra_reg, umid_amostra_reg;
    logic [7:0]    temp_buf_reg  [4];
    logic [7:0]    umid_buf_reg  [4];
    logic [7:0]    temp_buf_next [4];
    logic [7:0]    umid_buf_next [4];
    logic          primed_reg;
    logic [9:0]    temp_soma, umid_soma;
    logic [7:0]    temp_media_reg, umid_media_reg;
    logic          dado_valido_reg, alarme_reg, falha_sensor_reg;
    logic [3:0]    contagem_erros_reg, contagem_erros_inc;
    logic [7:0]    limiar_limpa;
    logic          unused_decimais;

    // Decimal parts of the sensor words are not used by the averages.
    assign unused_decimais = ^{temperatura[7:0], umidade[7:0]};

    always_ff @(posedge clock) begin
        if (!reset) estado_reg <= OCIOSO;
        else        estado_reg <= estado_next;
    end

    always_comb begin
        estado_next = estado_reg;
        case (estado_reg)
            OCIOSO:   if (habilitar) estado_next = DISPARA;
            ESPERA: begin
                if (!habilitar)
                    estado_next = OCIOSO;
                else if (periodo_cnt_reg == PERIODO_ULT || medir_agora)
                    estado_next = DISPARA;
            end
            DISPARA:  estado_next = AGUARDA;
            AGUARDA: begin
                if (pronto)
                    estado_next = REGISTRA;
                else if (erro || timeout_cnt_reg == TIMEOUT_ULT)
                    estado_next = FALHA;
            end
            REGISTRA: estado_next = habilitar ? ESPERA : OCIOSO;
            FALHA:    estado_next = habilitar ? ESPERA : OCIOSO;
            default:  estado_next = OCIOSO;
        endcase
    end

    // Counters sit at zero outside their own state, so entering it always starts from 0.
    always_ff @(posedge clock) begin
        if (!reset) begin
            periodo_cnt_reg <= '0;
            timeout_cnt_reg <= '0;
        end else begin
            periodo_cnt_reg <= (estado_reg == ESPERA)  ? periodo_cnt_reg + 1'b1 : '0;
            timeout_cnt_reg <= (estado_reg == AGUARDA) ? timeout_cnt_reg + 1'b1 : '0;
        end
    end

    // Before the first sample every slot takes the new value, otherwise the buffer shifts.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_buf
            if (gi == 0) begin : g_cab
                assign temp_buf_next[gi] = temp_amostra_reg;
                assign umid_buf_next[gi] = umid_amostra_reg;
            end else begin : g_corpo
                assign temp_buf_next[gi] = primed_reg ? temp_buf_reg[gi-1] : temp_amostra_reg;
                assign umid_buf_next[gi] = primed_reg ? umid_buf_reg[gi-1] : umid_amostra_reg;
            end
        end
    endgenerate

    always_comb begin
        temp_soma = '0;
        umid_soma = '0;
        for (int i = 0; i < 4; i++) begin
            temp_soma = temp_soma + {2'b00, temp_buf_next[i]};
            umid_soma = umid_soma + {2'b00, umid_buf_next[i]};
        end
    end

    assign contagem_erros_inc = (contagem_erros_reg == 4'hF) ? 4'hF : contagem_erros_reg + 4'd1;
    assign limiar_limpa = (limiar_temp < 8'(HISTERESE)) ? 8'd0 : limiar_temp - 8'(HISTERESE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            temp_amostra_reg   <= '0;
            umid_amostra_reg   <= '0;
            for (int i = 0; i < 4; i++) begin
                temp_buf_reg[i] <= '0;
                umid_buf_reg[i] <= '0;
            end
            primed_reg         <= 1'b0;
            temp_media_reg     <= '0;
            umid_media_reg     <= '0;
            dado_valido_reg    <= 1'b0;
            alarme_reg         <= 1'b0;
            falha_sensor_reg   <= 1'b0;
            contagem_erros_reg <= '0;
        end else begin
            dado_valido_reg <= 1'b0;
            if (estado_reg == AGUARDA && pronto) begin
                temp_amostra_reg <= temperatura[15:8];
                umid_amostra_reg <= umidade[15:8];
            end
            if (estado_reg == REGISTRA) begin
                for (int i = 0; i < 4; i++) begin
                    temp_buf_reg[i] <= temp_buf_next[i];
                    umid_buf_reg[i] <= umid_buf_next[i];
                end
                primed_reg         <= 1'b1;
                temp_media_reg     <= 8'(temp_soma >> 2);
                umid_media_reg     <= 8'(umid_soma >> 2);
                dado_valido_reg    <= 1'b1;
                contagem_erros_reg <= '0;
                falha_sensor_reg   <= 1'b0;
            end
            if (estado_reg == FALHA) begin
                contagem_erros_reg <= contagem_erros_inc;
                if (32'(contagem_erros_inc) >= MAX_ERROS)
                    falha_sensor_reg <= 1'b1;
            end
            // The alarm only reacts to a freshly published average.
            if (dado_valido_reg) begin
                if (temp_media_reg > limiar_temp)
                    alarme_reg <= 1'b1;
                else if (temp_media_reg < limiar_limpa)
                    alarme_reg <= 1'b0;
            end
        end
    end

    assign medir          = (estado_reg == DISPARA);
    assign temp_media     = temp_media_reg;
    assign umid_media     = umid_media_reg;
    assign dado_valido    = dado_valido_reg;
    assign alarme         = alarme_reg;
    assign falha_sensor   = falha_sensor_reg;
    assign contagem_erros = contagem_erros_reg;
    assign db_estado      = estado_reg;
endmodule

// File: tb/tb_agendador_medidas_dht11.sv
// Bench for agendador_medidas_dht11: a queue-based behavioural model is compared with the DUT every cycle.
// Directed scenarios plus randomized handshake responses; a few literal values pin the model.
module tb_agendador_medidas_dht11;
    localparam int PERIODO          = 20;
    localparam int TIMEOUT_RESPOSTA = 10;
    localparam int MAX_ERROS        = 3;
    localparam int HISTERESE        = 2;

    logic        clock = 1'b0;
    logic        reset, habilitar, medir_agora, pronto, erro;
    logic [15:0] temperatura, umidade;
    logic [7:0]  limiar_temp;
    logic        medir, dado_valido, alarme, falha_sensor;
    logic [7:0]  temp_media, umid_media;
    logic [3:0]  contagem_erros;
    logic [2:0]  db_estado;

    always #5 clock = ~clock;

    agendador_medidas_dht11 #(
        .PERIODO(PERIODO), .TIMEOUT_RESPOSTA(TIMEOUT_RESPOSTA),
        .MAX_ERROS(MAX_ERROS), .HISTERESE(HISTERESE)
    ) dut (
        .clock(clock), .reset(reset), .habilitar(habilitar), .medir_agora(medir_agora),
        .pronto(pronto), .erro(erro), .temperatura(temperatura), .umidade(umidade),
        .limiar_temp(limiar_temp), .medir(medir), .temp_media(temp_media),
        .umid_media(umid_media), .dado_valido(dado_valido), .alarme(alarme),
        .falha_sensor(falha_sensor), .contagem_erros(contagem_erros), .db_estado(db_estado)
    );

    int n_aval = 0;
    int n_falhas = 0;
    int n_trans = 0;
    bit comparar = 1'b0;

    task automatic checar(input string nome, input logic [15:0] obtido, input logic [15:0] esperado);
        n_aval++;
        if (obtido !== esperado) begin
            n_falhas++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, obtido, esperado, $time);
        end
    endtask

    // Behavioural model: phase number is the observable db_estado value.
    int m_fase, m_espera, m_aguarda, m_amostra_t, m_amostra_u;
    int m_tmed, m_umed, m_erros;
    bit m_dv, m_alarme, m_falha;
    int hist_t[$];
    int hist_u[$];
    int log_tmed[$];

    task automatic passo_modelo();
        int prox;
        int st, su;
        bit dv_novo;
        if (!reset) begin
            m_fase = 0; m_espera = 0; m_aguarda = 0; m_amostra_t = 0; m_amostra_u = 0;
            m_tmed = 0; m_umed = 0; m_erros = 0; m_dv = 0; m_alarme = 0; m_falha = 0;
            hist_t.delete(); hist_u.delete();
            return;
        end
        if (m_dv) begin
            if (m_tmed > int'(limiar_temp)) m_alarme = 1'b1;
            else if (m_tmed + HISTERESE < int'(limiar_temp)) m_alarme = 1'b0;
        end
        prox = m_fase;
        dv_novo = 1'b0;
        case (m_fase)
            0: if (habilitar) prox = 2;
            1: begin
                if (!habilitar) prox = 0;
                else if (m_espera == PERIODO - 1 || medir_agora) prox = 2;
                m_espera++;
            end
            2: begin prox = 3; m_aguarda = 0; end
            3: begin
                if (pronto) begin
                    prox = 4;
                    m_amostra_t = int'(temperatura[15:8]);
                    m_amostra_u = int'(umidade[15:8]);
                end else if (erro || m_aguarda == TIMEOUT_RESPOSTA - 1) prox = 5;
                m_aguarda++;
            end
            4: begin
                if (hist_t.size() == 0)
                    repeat (3) begin hist_t.push_back(m_amostra_t); hist_u.push_back(m_amostra_u); end
                hist_t.push_front(m_amostra_t);
                hist_u.push_front(m_amostra_u);
                if (hist_t.size() > 4) begin void'(hist_t.pop_back()); void'(hist_u.pop_back()); end
                st = 0; su = 0;
                foreach (hist_t[i]) st += hist_t[i];
                foreach (hist_u[i]) su += hist_u[i];
                m_tmed = st / 4;
                m_umed = su / 4;
                log_tmed.push_back(m_tmed);
                dv_novo = 1'b1;
                m_erros = 0;
                m_falha = 1'b0;
                prox = habilitar ? 1 : 0;
            end
            5: begin
                if (m_erros < 15) m_erros++;
                if (m_erros >= MAX_ERROS) m_falha = 1'b1;
                prox = habilitar ? 1 : 0;
            end
            default: prox = 0;
        endcase
        if (prox == 1 && m_fase != 1) m_espera = 0;
        m_fase = prox;
        m_dv = dv_novo;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            passo_modelo();
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (comparar) begin
                checar("medir",          16'(medir),          16'(m_fase == 2));
                checar("temp_media",     16'(temp_media),     16'(m_tmed));
                checar("umid_media",     16'(umid_media),     16'(m_umed));
                checar("dado_valido",    16'(dado_valido),    16'(m_dv));
                checar("alarme",         16'(alarme),         16'(m_alarme));
                checar("falha_sensor",   16'(falha_sensor),   16'(m_falha));
                checar("contagem_erros", 16'(contagem_erros), 16'(m_erros));
                checar("db_estado",      16'(db_estado),      16'(m_fase));
            end
        end
    end

    // Returns at the negedge where medir is high; optional noise on ignored inputs.
    task automatic esperar_medir(input bit ruido, output int ciclos);
        ciclos = 0;
        forever begin
            @(negedge clock);
            ciclos++;
            if (medir === 1'b1) begin
                pronto = 1'b0; erro = 1'b0; medir_agora = 1'b0;
                break;
            end
            if (ciclos >= 200) begin
                n_aval++;
                n_falhas++;
                $display("FAIL medir_timeout: no medir after %0d cycles (t=%0t)", ciclos, $time);
                pronto = 1'b0; erro = 1'b0; medir_agora = 1'b0;
                break;
            end
            if (ruido) begin
                pronto      = ($urandom % 8 == 0);
                erro        = ($urandom % 8 == 0);
                medir_agora = ($urandom % 16 == 0);
            end
        end
    endtask

    // Called at the medir negedge. tipo: 0 pronto, 1 erro, 2 both, 3 no answer.
    task automatic responder(input int atraso, input int tipo, input logic [7:0] t,
                             input logic [7:0] u, input bit ver_lat);
        $display("trans %0d: tipo=%0d atraso=%0d temp=%0d umid=%0d limiar=%0d hab=%0d",
                 n_trans, tipo, atraso, t, u, limiar_temp, habilitar);
        n_trans++;
        if (tipo == 3) return;
        repeat (atraso + 1) @(negedge clock);
        temperatura = {t, 8'($urandom)};
        umidade     = {u, 8'($urandom)};
        pronto = (tipo == 0 || tipo == 2);
        erro   = (tipo == 1 || tipo == 2);
        @(negedge clock);
        pronto = 1'b0;
        erro   = 1'b0;
        if (ver_lat && tipo != 1) begin
            @(negedge clock);
            checar("latencia_dado_valido", 16'(dado_valido), 16'd1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, tipo, r;
        bit ruido_prox;
        reset = 1'b0; habilitar = 1'b0; medir_agora = 1'b0; pronto = 1'b0; erro = 1'b0;
        temperatura = '0; umidade = '0; limiar_temp = 8'd26;
        repeat (3) @(negedge clock);
        comparar = 1'b1;
        checar("reset_db_estado", 16'(db_estado), 16'd0);
        checar("reset_temp_media", 16'(temp_media), 16'd0);
        reset = 1'b1;
        @(negedge clock);
        habilitar = 1'b1;
        esperar_medir(1'b0, c);
        checar("primeiro_medir_ciclos", 16'(c), 16'd1);

        // First sample primes the buffer.
        responder(0, 0, 8'd25, 8'd60, 1'b1);
        checar("primeira_temp_media", 16'(temp_media), 16'd25);
        checar("primeira_umid_media", 16'(umid_media), 16'd60);
        esperar_medir(1'b0, c);
        checar("periodo_ciclos", 16'(c), 16'(PERIODO));

        for (int i = 0; i < 3; i++) begin
            if (i > 0) esperar_medir(1'b1, c);
            responder($urandom_range(0, 9), 0, 8'(27 + 2 * i), 8'($urandom_range(20, 90)), 1'b1);
        end
        checar("media_28", 16'(temp_media), 16'd28);
        @(negedge clock);
        checar("alarme_liga", 16'(alarme), 16'd1);
        checar("modelo_media0", 16'(log_tmed[0]), 16'd25);
        checar("modelo_media1", 16'(log_tmed[1]), 16'd25);
        checar("modelo_media2", 16'(log_tmed[2]), 16'd26);
        checar("modelo_media3", 16'(log_tmed[3]), 16'd28);

        // Averages 27, 27, 25, 24, 23: 24 is not below 26-2, 23 is.
        for (int i = 0; i < 5; i++) begin
            esperar_medir(1'b1, c);
            responder($urandom_range(0, 9), 0, (i < 4) ? 8'd24 : 8'd20, 8'd50, 1'b1);
            @(negedge clock);
            if (i == 3) checar("alarme_mantem_24", 16'(alarme), 16'd1);
        end
        checar("alarme_desliga_23", 16'(alarme), 16'd0);

        // Three unanswered triggers.
        esperar_medir(1'b1, c);
        responder(0, 3, 8'd0, 8'd0, 1'b0);
        esperar_medir(1'b0, c);
        responder(0, 3, 8'd0, 8'd0, 1'b0);
        esperar_medir(1'b0, c);
        checar("erros_2", 16'(contagem_erros), 16'd2);
        checar("falha_2", 16'(falha_sensor), 16'd0);
        responder(0, 3, 8'd0, 8'd0, 1'b0);
        esperar_medir(1'b0, c);
        checar("erros_3", 16'(contagem_erros), 16'd3);
        checar("falha_3", 16'(falha_sensor), 16'd1);
        checar("timeout_ciclos", 16'(c), 16'(TIMEOUT_RESPOSTA + PERIODO + 2));
        responder($urandom_range(0, 9), 0, 8'd33, 8'd44, 1'b1);
        checar("erros_limpos", 16'(contagem_erros), 16'd0);
        checar("falha_limpa", 16'(falha_sensor), 16'd0);

        // pronto and erro together, then erro alone.
        esperar_medir(1'b1, c);
        responder(3, 2, 8'd40, 8'd50, 1'b1);
        checar("ambos_erros", 16'(contagem_erros), 16'd0);
        esperar_medir(1'b1, c);
        responder(1, 1, 8'd41, 8'd51, 1'b0);
        esperar_medir(1'b1, c);
        checar("erro_so", 16'(contagem_erros), 16'd1);

        // medir_agora at period count 5.
        responder(0, 0, 8'd30, 8'd40, 1'b1);
        repeat (5) @(negedge clock);
        medir_agora = 1'b1;
        @(negedge clock);
        medir_agora = 1'b0;
        checar("medir_agora", 16'(medir), 16'd1);

        // habilitar dropped while a measurement is in flight.
        habilitar = 1'b0;
        responder(2, 0, 8'd32, 8'd42, 1'b1);
        @(negedge clock);
        checar("ocioso_apos_hab0", 16'(db_estado), 16'd0);
        repeat (5) @(negedge clock);
        checar("sem_medir_hab0", 16'(medir), 16'd0);
        habilitar = 1'b1;
        esperar_medir(1'b0, c);
        checar("religa_ciclos", 16'(c), 16'd1);

        // Reset in the middle of AGUARDA, then re-prime.
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checar("reset_meio_estado", 16'(db_estado), 16'd0);
        checar("reset_meio_media", 16'(temp_media), 16'd0);
        checar("reset_meio_alarme", 16'(alarme), 16'd0);
        reset = 1'b1;
        esperar_medir(1'b0, c);
        responder(0, 0, 8'd30, 8'd70, 1'b1);
        checar("reprime_temp", 16'(temp_media), 16'd30);
        checar("reprime_umid", 16'(umid_media), 16'd70);

        // Randomized transactions.
        ruido_prox = 1'b1;
        for (int k = 0; k < 30; k++) begin
            r = int'($urandom % 8);
            tipo = (r < 5) ? 0 : (r == 5) ? 1 : (r == 6) ? 2 : 3;
            esperar_medir(ruido_prox, c);
            limiar_temp = 8'($urandom_range(15, 45));
            responder($urandom_range(0, 9), tipo, 8'($urandom_range(0, 60)),
                      8'($urandom_range(0, 99)), 1'b0);
            ruido_prox = (tipo != 3);
        end

        repeat (4) @(negedge clock);
        comparar = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_aval, n_falhas);
        $finish;
    end
endmodule
